// File: rtl/data_memory_if.sv
// -----------------------------------------------------------------------------
// data_memory_if
// Request/response bus for data_memory.
//
// Handshake (both channels): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and its payload
// stable until the transfer; the consumer may change ready at any time.
// The request channel carries req_wr/req_addr/req_wdata/req_be, the response
// channel carries rsp_rdata/rsp_err.
//
// Modports:
//   master - issues requests, consumes responses (testbench / CPU side)
//   slave  - accepts requests, produces responses (memory side)
// -----------------------------------------------------------------------------
interface data_memory_if #(
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [31:0]           req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Word-organised, byte-lane-writable data memory with a fixed-latency,
// stallable response pipeline.
//
// Parameters:
//   DATA_W - word width in bits (multiple of 8, 8..128)
//   DEPTH  - number of words (power of two, 16..65536)
//   RD_LAT - response latency in cycles (1..4)
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset (clears the response pipeline only;
//           the memory array is never reset)
//   bus   - data_memory_if.slave request/response bus
//
// Behaviour:
//   - Word index is the byte address shifted by log2(DATA_W/8). Non-zero low
//     address bits (misaligned) or any index >= DEPTH (out of range, with
//     upper address bits checked so nothing aliases) make the request an
//     error: memory is untouched and the response has rsp_err=1, rdata=0.
//   - Writes commit at the accept edge; reads sample the array at the accept
//     edge, so a write accepted one cycle earlier is already visible.
//   - Every accepted request yields exactly one in-order response RD_LAT
//     cycles later. The whole pipeline freezes while the output stage holds
//     a response that is not being consumed.
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_memory_if.slave   bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic             misaligned;
    logic             out_of_range;
    logic             req_err;
    logic [IDX_W-1:0] word_idx;
    logic             advance;
    logic             accept;
    logic             mem_we;

    generate
        if (OFF_W == 0) begin : g_no_offset
            assign misaligned = 1'b0;
        end else begin : g_offset
            assign misaligned = |bus.req_addr[OFF_W-1:0];
        end
    endgenerate

    // Any set bit above the index field means the index is >= DEPTH.
    assign out_of_range = |bus.req_addr[31:OFF_W+IDX_W];
    assign req_err      = misaligned | out_of_range;
    assign word_idx     = bus.req_addr[OFF_W +: IDX_W];

    // The pipeline moves whenever the output stage is not blocked; a new
    // request can only enter when the pipeline moves.
    assign advance       = !(bus.rsp_valid && !bus.rsp_ready);
    assign bus.req_ready = advance;
    assign accept        = bus.req_valid && advance;

    // A request presented during reset gets no response, so it must not
    // leave a side effect in memory either.
    assign mem_we = accept && bus.req_wr && !req_err && rst_n;

    // -------------------------------------------------------------------------
    // Storage (not reset)
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.req_be[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[word_idx];

    // -------------------------------------------------------------------------
    // Response pipeline: stage 0 is loaded at the accept edge, stage RD_LAT-1
    // drives the outputs. Empty slots carry valid=0 with zero payload so
    // bubbles come out clean.
    // -------------------------------------------------------------------------
    logic              stg_valid [RD_LAT];
    logic [DATA_W-1:0] stg_rdata [RD_LAT];
    logic              stg_err   [RD_LAT];

    logic              new_valid;
    logic [DATA_W-1:0] new_rdata;
    logic              new_err;

    always_comb begin
        new_valid = accept;
        new_err   = accept && req_err;
        new_rdata = '0;
        if (accept && !bus.req_wr && !req_err) begin
            new_rdata = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stg_valid[i] <= 1'b0;
                stg_rdata[i] <= '0;
                stg_err[i]   <= 1'b0;
            end
        end else if (advance) begin
            stg_valid[0] <= new_valid;
            stg_rdata[0] <= new_rdata;
            stg_err[0]   <= new_err;
            for (int i = 1; i < RD_LAT; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_rdata[i] <= stg_rdata[i-1];
                stg_err[i]   <= stg_err[i-1];
            end
        end
    end

    assign bus.rsp_valid = stg_valid[RD_LAT-1];
    assign bus.rsp_rdata = stg_rdata[RD_LAT-1];
    assign bus.rsp_err   = stg_err[RD_LAT-1];

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8, range 8..128.
REQ-002 Parameter DEPTH, default 256, number of words; SHALL be a power of two, range 16..65536.
REQ-003 Parameter RD_LAT, default 1, response latency in cycles; SHALL be in range 1..4.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-008 req_wr  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 req_be  in  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i].
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
REQ-015 rsp_err  out  1  request was misaligned or out of range.

Function
REQ-016 Word index SHALL be req_addr >> log2(DATA_W/8); the request is misaligned if any of the low log2(DATA_W/8) address bits is nonzero.
REQ-017 The request is out of range if the word index is >= DEPTH; upper address bits SHALL NOT alias.
REQ-018 Acceptance: req_valid && req_ready at a rising edge; at most one request per cycle.
REQ-019 req_ready SHALL equal !(rsp_valid && !rsp_ready), combinationally.
REQ-020 Accepted write, no error: each lane with req_be[i]=1 SHALL be updated at the accept edge; lanes with req_be[i]=0 SHALL be unchanged.
REQ-021 Accepted write with req_be all zero SHALL not modify memory and SHALL still produce a response with rsp_err=0.
REQ-022 Accepted read, no error: rsp_rdata SHALL be the word contents as of the accept edge, including a write accepted in the immediately preceding cycle.
REQ-023 Erroneous request (misaligned or out of range): memory SHALL be unmodified; the response SHALL carry rsp_err=1 and rsp_rdata=0.
REQ-024 Every accepted request, read or write, SHALL produce exactly one response, in order.
REQ-025 With rsp_ready held high, the response to a request accepted at edge t SHALL be valid in the cycle following edge t+RD_LAT-1, i.e. RD_LAT cycles after acceptance.
REQ-026 Responses SHALL flow through an RD_LAT-stage pipeline.
REQ-027 While rsp_valid && !rsp_ready, all pipeline stages SHALL hold, and rsp_valid, rsp_rdata and rsp_err SHALL stay stable.
REQ-028 Back-to-back requests with no stall SHALL sustain one response per cycle.
REQ-029 Bubbles (cycles with no accepted request) SHALL propagate as rsp_valid=0 with rsp_rdata=0 and rsp_err=0.

Reset
REQ-030 While rst_n=0: rsp_valid=0, rsp_rdata=0, rsp_err=0, and all pipeline valid bits cleared; req_ready therefore reads 1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight responses.
REQ-032 Writes already committed before reset assertion SHALL be retained.
REQ-033 Memory array contents SHALL NOT be reset; they are undefined until first written.
REQ-034 After rst_n deasserts, the first request SHALL be acceptable at the first rising edge.

Verification
REQ-035 Scenario, RD_LAT=1, DATA_W=32: write addr 0x8, data 0xDEADBEEF, be 0xF, then read 0x8 -> read rsp_rdata=0xDEADBEEF, rsp_err=0, one cycle after read accept.
REQ-036 Scenario, partial write: write 0x8, data 0x000000AA, be 0x1, onto word 0xDEADBEEF, then read 0x8 -> 0xDEADBEAA.
REQ-037 Scenario, errors: read 0x6 (misaligned), then read 0x400 with DEPTH=256 (out of range) -> both responses rsp_err=1, rsp_rdata=0; contents of 0x4 and 0x0 unchanged.
REQ-038 Scenario, RD_LAT=3, 4 back-to-back reads with rsp_ready=1 -> responses on 4 consecutive cycles, the first 3 cycles after the first accept, in order.
REQ-039 Scenario, stall: hold rsp_ready=0 for 5 cycles while a response is valid -> req_ready=0 and outputs stable throughout; no request lost; order preserved after release.
REQ-040 Scenario, reset: assert rst_n=0 with 2 reads in flight -> rsp_valid=0 immediately, no stale response after release; a prior write is still readable.
